// File: rtl/fpu_pkg.sv
// fpu_pkg: constants shared by the floating-point blocks: default format,
// rounding-mode encodings and exception-flag bit positions.
package fpu_pkg;

  localparam int FPU_EXPW  = 8;
  localparam int FPU_FRACW = 23;

  // Encodings 101-111 are unused and fold onto RNE at the point of use.
  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  // Flag vector layout: {NV, DZ, OF, UF, NX}
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

endpackage

// File: rtl/fp_lzc_norm.sv
// fp_lzc_norm: leading-zero count and left shift, with the shift clamped to
// lim so the caller's exponent never drops below its minimum.
module fp_lzc_norm #(
  parameter int WIDTH = 27,
  parameter int LW    = 9
) (
  input  logic [WIDTH-1:0] din,
  input  logic [LW-1:0]    lim,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    shamt
);

  logic [LW-1:0] lzc;
  logic          found;

  // Priority scan from the MSB; an all-zero input counts as WIDTH zeros.
  always_comb begin
    lzc   = LW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && din[i]) begin
        lzc   = LW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign shamt = (lzc < lim) ? lzc : lim;
  assign dout  = din << shamt;

endmodule

// File: rtl/fadd_pipe.sv
// fadd_pipe: 3-stage floating-point adder/subtractor.
//   S1 unpack, special-case detect, magnitude compare/swap, exponent diff
//   S2 align smaller operand (guard/round/sticky) and add/subtract
//   S3 normalise, round, pack, raise flags
// Issue protocol: an operation is accepted on a rising edge where req=1 and
// stall=0; stall=1 freezes every stage and the outputs (req is dropped, not
// queued); vld marks a result that is consumed on the next unstalled edge.
module fadd_pipe
  import fpu_pkg::*;
#(
  parameter int EXPW  = FPU_EXPW,
  parameter int FRACW = FPU_FRACW,
  parameter logic [EXPW+FRACW:0] DNAN = {1'b1, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  sub,
  input  logic [2:0]            rm,
  input  logic [EXPW+FRACW:0]   x,
  input  logic [EXPW+FRACW:0]   y,
  input  logic                  stall,
  output logic                  vld,
  output logic [EXPW+FRACW:0]   rslt,
  output logic [4:0]            flag
);

  localparam int W  = 1 + EXPW + FRACW;
  localparam int M  = FRACW + 1;      // mantissa with hidden bit
  localparam int X  = FRACW + 4;      // mantissa plus guard/round/sticky
  localparam int EW = EXPW + 1;       // exponent arithmetic with headroom
  localparam logic [EXPW-1:0] SHMAX = EXPW'(X);
  localparam logic [W-1:0]    QBIT  = {{(EXPW+1){1'b0}}, 1'b1, {(FRACW-1){1'b0}}};

  // ---------------- S1 ----------------
  logic            xs, ys, x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_ge;
  logic [EXPW-1:0] xe, ye, xe_e, ye_e;
  logic [M-1:0]    xm, ym;
  logic            sp, sp_nv;
  logic [W-1:0]    sp_r;

  assign xs     = x[W-1];
  assign ys     = y[W-1] ^ sub;
  assign xe     = x[W-2:FRACW];
  assign ye     = y[W-2:FRACW];
  assign x_nan  = (&xe) & (|x[FRACW-1:0]);
  assign y_nan  = (&ye) & (|y[FRACW-1:0]);
  assign x_snan = x_nan & ~x[FRACW-1];
  assign y_snan = y_nan & ~y[FRACW-1];
  assign x_inf  = (&xe) & ~(|x[FRACW-1:0]);
  assign y_inf  = (&ye) & ~(|y[FRACW-1:0]);
  // Exponent field 0 behaves as exponent 1 with a zero hidden bit.
  assign xe_e   = (xe == '0) ? EXPW'(1) : xe;
  assign ye_e   = (ye == '0) ? EXPW'(1) : ye;
  assign xm     = {|xe, x[FRACW-1:0]};
  assign ym     = {|ye, y[FRACW-1:0]};
  // Raw magnitude bits order the same way as the values they encode.
  assign x_ge   = x[W-2:0] >= y[W-2:0];

  // Special operands resolve here and ride alongside the datapath.
  always_comb begin
    sp    = 1'b0;
    sp_nv = 1'b0;
    sp_r  = '0;
    if (x_nan) begin
      sp    = 1'b1;
      sp_nv = x_snan | y_snan;
      sp_r  = x | QBIT;
    end else if (y_nan) begin
      sp    = 1'b1;
      sp_nv = y_snan;
      sp_r  = y | QBIT;
    end else if (x_inf && y_inf && (xs != ys)) begin
      sp    = 1'b1;
      sp_nv = 1'b1;
      sp_r  = DNAN;
    end else if (x_inf) begin
      sp    = 1'b1;
      sp_r  = x;
    end else if (y_inf) begin
      sp    = 1'b1;
      sp_r  = {ys, y[W-2:0]};
    end
  end

  logic            s1_v, s1_sa, s1_sb, s1_sp, s1_spnv;
  logic [EXPW-1:0] s1_e, s1_d;
  logic [M-1:0]    s1_ma, s1_mb;
  rm_e             s1_rm;
  logic [W-1:0]    s1_spr;

  // S1 register: larger-magnitude operand always lands in the 'a' slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
    end else if (!stall) begin
      s1_v    <= req;
      s1_sa   <= x_ge ? xs : ys;
      s1_sb   <= x_ge ? ys : xs;
      s1_e    <= x_ge ? xe_e : ye_e;
      s1_ma   <= x_ge ? xm : ym;
      s1_mb   <= x_ge ? ym : xm;
      s1_d    <= x_ge ? (xe_e - ye_e) : (ye_e - xe_e);
      s1_rm   <= (rm > 3'd4) ? RM_RNE : rm_e'(rm);
      s1_sp   <= sp;
      s1_spnv <= sp_nv;
      s1_spr  <= sp_r;
    end
  end

  // ---------------- S2 ----------------
  logic [EXPW-1:0] sh;
  logic [2*X-1:0]  wide;
  logic [X-1:0]    a_ext, b_al;
  logic [X:0]      sum_raw, sum_abs;
  logic            eff_sub, neg;

  assign eff_sub = s1_sa ^ s1_sb;
  assign sh      = (s1_d > SHMAX) ? SHMAX : s1_d;
  assign wide    = {s1_mb, 3'b000, {X{1'b0}}} >> sh;
  // Everything shifted past the sticky position collapses into it.
  assign b_al    = {wide[2*X-1:X+1], wide[X] | (|wide[X-1:0])};
  assign a_ext   = {s1_ma, 3'b000};
  assign sum_raw = eff_sub ? ({1'b0, a_ext} - {1'b0, b_al}) : ({1'b0, a_ext} + {1'b0, b_al});
  // The swap keeps a >= b, but a borrow is still folded back to a magnitude.
  assign neg     = eff_sub & sum_raw[X];
  assign sum_abs = neg ? (~sum_raw + (X+1)'(1)) : sum_raw;

  logic            s2_v, s2_s, s2_sa, s2_sb, s2_sp, s2_spnv;
  logic [EXPW-1:0] s2_e;
  logic [X:0]      s2_sum;
  rm_e             s2_rm;
  logic [W-1:0]    s2_spr;

  // S2 register: raw sum with its carry bit and the result sign.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v <= 1'b0;
    end else if (!stall) begin
      s2_v    <= s1_v;
      s2_s    <= s1_sa ^ neg;
      s2_sa   <= s1_sa;
      s2_sb   <= s1_sb;
      s2_e    <= s1_e;
      s2_sum  <= sum_abs;
      s2_rm   <= s1_rm;
      s2_sp   <= s1_sp;
      s2_spnv <= s1_spnv;
      s2_spr  <= s1_spr;
    end
  end

  // ---------------- S3 ----------------
  logic [EW-1:0]    e_c, lim, shamt, e_n, e_r;
  logic [X-1:0]     nin, n;
  logic             g, rs, inexact, up, hid, ovf, to_inf, zsign;
  logic [M:0]       mr;
  logic [FRACW-1:0] fr;
  logic [W-1:0]     res;
  logic [4:0]       fl;

  // A carry out of the add renormalises right by one, keeping sticky.
  always_comb begin
    if (s2_sum[X]) begin
      nin = {s2_sum[X:2], |s2_sum[1:0]};
      e_c = {1'b0, s2_e} + EW'(1);
    end else begin
      nin = s2_sum[X-1:0];
      e_c = {1'b0, s2_e};
    end
  end

  assign lim = e_c - EW'(1);

  fp_lzc_norm #(.WIDTH(X), .LW(EW)) u_norm (
    .din   (nin),
    .lim   (lim),
    .dout  (n),
    .shamt (shamt)
  );

  assign e_n = e_c - shamt;

  // Round on guard/round/sticky, then pack or substitute special results.
  always_comb begin
    g       = n[2];
    rs      = |n[1:0];
    inexact = g | rs;
    case (s2_rm)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = inexact & s2_s;
      RM_RUP:  up = inexact & ~s2_s;
      RM_RMM:  up = g;
      default: up = g & (rs | n[3]);
    endcase
    mr = {1'b0, n[X-1:3]} + (M+1)'(up);
    if (mr[M]) begin
      hid = 1'b1;
      fr  = mr[M-1:1];
      e_r = e_n + EW'(1);
    end else begin
      hid = mr[M-1];
      fr  = mr[M-2:0];
      e_r = e_n;
    end
    ovf    = hid & (e_r >= {1'b0, {EXPW{1'b1}}});
    to_inf = (s2_rm == RM_RNE) | (s2_rm == RM_RMM) |
             ((s2_rm == RM_RUP) & ~s2_s) | ((s2_rm == RM_RDN) & s2_s);
    // Equal signs only cancel when both are zero; otherwise mode decides.
    zsign  = (s2_sa == s2_sb) ? s2_sa : (s2_rm == RM_RDN);
    res    = {s2_s, (hid ? e_r[EXPW-1:0] : {EXPW{1'b0}}), fr};
    fl     = '0;
    if (s2_sp) begin
      res         = s2_spr;
      fl[FLG_NV]  = s2_spnv;
    end else if (s2_sum == '0) begin
      res         = {zsign, {(W-1){1'b0}}};
    end else if (ovf) begin
      res         = to_inf ? {s2_s, {EXPW{1'b1}}, {FRACW{1'b0}}}
                           : {s2_s, {(EXPW-1){1'b1}}, 1'b0, {FRACW{1'b1}}};
      fl[FLG_OF]  = 1'b1;
      fl[FLG_NX]  = 1'b1;
    end else begin
      fl[FLG_NX]  = inexact;
      fl[FLG_UF]  = inexact & ~hid;
    end
  end

  // S3 register doubles as the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= 1'b0;
      rslt <= '0;
      flag <= '0;
    end else if (!stall) begin
      vld  <= s2_v;
      rslt <= res;
      flag <= fl;
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// tb_fadd_pipe: scoreboard bench for fadd_pipe at the default 8/23 format.
module tb_fadd_pipe;
  import fpu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset, req, sub, stall;
  logic [2:0]   rm;
  logic [W-1:0] x, y, rslt;
  logic         vld;
  logic [4:0]   flag;

  always #5 clk = ~clk;

  fadd_pipe dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .sub   (sub),
    .rm    (rm),
    .x     (x),
    .y     (y),
    .stall (stall),
    .vld   (vld),
    .rslt  (rslt),
    .flag  (flag)
  );

  // ---------------- scoreboard ----------------
  int             total = 0;
  int             bad   = 0;
  logic [W+4:0]   exp_q[$];
  string          name_q[$];
  logic [W+4:0]   mon_e;
  string          mon_n;

  // A result is consumed on the edge after a negedge where vld=1, stall=0.
  always @(negedge clk) begin
    if (!reset && vld && !stall) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_vld: got rslt=%h flag=%h, required no output", rslt, flag);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if ({rslt, flag} !== mon_e) begin
          bad++;
          $display("FAIL %s: got rslt=%h flag=%h, required rslt=%h flag=%h",
                   mon_n, rslt, flag, mon_e[W+4:5], mon_e[4:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic si,
                       input logic [2:0] ri, input logic [W-1:0] er, input logic [4:0] ef,
                       input string nm);
    x   = xi;
    y   = yi;
    sub = si;
    rm  = ri;
    req = 1'b1;
    exp_q.push_back({er, ef});
    name_q.push_back(nm);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain(input string nm);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req = 1'b0; sub = 1'b0; stall = 1'b0; rm = 3'd0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (vld !== 1'b0)  begin bad++; $display("FAIL reset_vld: got %b, required 0", vld); end
    total++; if (rslt !== '0)   begin bad++; $display("FAIL reset_rslt: got %h, required 0", rslt); end
    total++; if (flag !== 5'd0) begin bad++; $display("FAIL reset_flag: got %h, required 0", flag); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    issue(32'h3f800000, 32'h3f800000, 1'b0, RM_RNE, 32'h40000000, 5'h00, "one_plus_one");
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL lat_c1: got vld=%b, required 0", vld); end
    @(posedge clk); #1;
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL lat_c2: got vld=%b, required 0", vld); end
    @(posedge clk); #1;
    total++; if (vld !== 1'b1) begin bad++; $display("FAIL lat_c3: got vld=%b, required 1", vld); end
    drain("latency");
  endtask

  task automatic test_arith();
    issue(32'h3fc00000, 32'h40200000, 1'b0, RM_RNE, 32'h40800000, 5'h00, "1p5_plus_2p5");
    issue(32'h3f800000, 32'h3f000000, 1'b1, RM_RNE, 32'h3f000000, 5'h00, "one_minus_half");
    issue(32'h3f800000, 32'h40000000, 1'b1, RM_RNE, 32'hbf800000, 5'h00, "one_minus_two");
    issue(32'h00000001, 32'h00000001, 1'b0, RM_RNE, 32'h00000002, 5'h00, "subn_plus_subn");
    issue(32'h00400000, 32'h00400000, 1'b0, RM_RNE, 32'h00800000, 5'h00, "subn_to_normal");
    drain("arith");
  endtask

  task automatic test_rounding();
    issue(32'h3f800000, 32'h33800000, 1'b0, RM_RNE, 32'h3f800000, 5'h01, "tie_rne");
    issue(32'h3f800000, 32'h33800000, 1'b0, RM_RUP, 32'h3f800001, 5'h01, "tie_rup");
    issue(32'h3f800000, 32'h33800000, 1'b0, RM_RDN, 32'h3f800000, 5'h01, "tie_rdn");
    issue(32'h3f800000, 32'h33800000, 1'b0, RM_RMM, 32'h3f800001, 5'h01, "tie_rmm");
    issue(32'h3f800000, 32'h33800000, 1'b0, 3'b111, 32'h3f800000, 5'h01, "tie_rm7");
    drain("rounding");
  endtask

  task automatic test_overflow();
    issue(32'h7f7fffff, 32'h7f7fffff, 1'b0, RM_RNE, 32'h7f800000, 5'h05, "ovf_rne");
    issue(32'h7f7fffff, 32'h7f7fffff, 1'b0, RM_RTZ, 32'h7f7fffff, 5'h05, "ovf_rtz");
    issue(32'h7f7fffff, 32'h7f7fffff, 1'b0, RM_RDN, 32'h7f7fffff, 5'h05, "ovf_rdn");
    issue(32'h7f7fffff, 32'h7f7fffff, 1'b0, RM_RUP, 32'h7f800000, 5'h05, "ovf_rup");
    issue(32'hff7fffff, 32'hff7fffff, 1'b0, RM_RDN, 32'hff800000, 5'h05, "ovf_neg_rdn");
    drain("overflow");
  endtask

  task automatic test_zero();
    issue(32'h3f800000, 32'h3f800000, 1'b1, RM_RNE, 32'h00000000, 5'h00, "cancel_rne");
    issue(32'h3f800000, 32'h3f800000, 1'b1, RM_RDN, 32'h80000000, 5'h00, "cancel_rdn");
    issue(32'h80000000, 32'h80000000, 1'b0, RM_RNE, 32'h80000000, 5'h00, "negz_plus_negz");
    drain("zero");
  endtask

  task automatic test_special();
    issue(32'h7f800000, 32'hff800000, 1'b0, RM_RNE, 32'hffc00000, 5'h10, "inf_minus_inf");
    issue(32'h7fa00000, 32'hff800000, 1'b0, RM_RNE, 32'h7fe00000, 5'h10, "snan_x");
    issue(32'h3f800000, 32'h7fc00001, 1'b0, RM_RNE, 32'h7fc00001, 5'h00, "qnan_y");
    issue(32'h7fc00000, 32'h7f800001, 1'b0, RM_RNE, 32'h7fc00000, 5'h10, "qnan_x_snan_y");
    issue(32'h7f800000, 32'h3f800000, 1'b0, RM_RNE, 32'h7f800000, 5'h00, "inf_plus_one");
    issue(32'h3f800000, 32'h7f800000, 1'b1, RM_RNE, 32'hff800000, 5'h00, "one_minus_inf");
    drain("special");
  endtask

  task automatic test_back_to_back();
    issue(32'h3f800000, 32'h3f800000, 1'b0, RM_RNE, 32'h40000000, 5'h00, "b2b_0");
    issue(32'h40000000, 32'h3f800000, 1'b0, RM_RNE, 32'h40400000, 5'h00, "b2b_1");
    // Requests during stall carry random operands and must vanish.
    stall = 1'b1;
    req   = 1'b1;
    x     = $urandom;
    y     = $urandom;
    sub   = 1'($urandom_range(0, 1));
    rm    = 3'($urandom_range(0, 4));
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 1'b0;
    req   = 1'b0;
    issue(32'h40400000, 32'h3f800000, 1'b0, RM_RNE, 32'h40800000, 5'h00, "b2b_2");
    issue(32'h40800000, 32'h3f800000, 1'b1, RM_RNE, 32'h40400000, 5'h00, "b2b_3");
    drain("b2b");
  endtask

  task automatic test_reset_flight();
    int seen = 0;
    x = 32'h3f800000; y = 32'h3f800000; sub = 1'b0; rm = RM_RNE; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req   = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (vld !== 1'b0)  begin bad++; $display("FAIL flight_vld: got %b, required 0", vld); end
    total++; if (rslt !== '0)   begin bad++; $display("FAIL flight_rslt: got %h, required 0", rslt); end
    repeat (8) begin
      @(posedge clk); #1;
      if (vld) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flight_emerge: got %0d vld cycles, required 0", seen); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_rounding();
    test_overflow();
    test_zero();
    test_special();
    test_back_to_back();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
